// File: rtl/proc_scheduler_if.sv
// Context-switch handshake between the scheduler and the control unit (UC).
// The scheduler drives the request side; the UC answers with switch_ack.
interface proc_scheduler_if;
  logic       switch_req;
  logic [3:0] next_pid;
  logic       switch_ack;

  modport master (output switch_req, output next_pid, input switch_ack);
  modport slave  (input switch_req, input next_pid, output switch_ack);
endinterface

// File: rtl/proc_scheduler.sv
// Round-robin preemptive scheduler over 16 PIDs: counts the running quantum,
// searches for the next active PID and requests a context switch from the UC.
module proc_scheduler #(
  parameter int          QW         = 16,
  parameter logic [15:0] RESET_MASK = 16'h0001
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [3:0]          cur_pid,
  input  logic [QW-1:0]       quantum,
  input  logic                yield,
  input  logic                proc_create,
  input  logic [3:0]          create_pid,
  input  logic                proc_kill,
  input  logic [3:0]          kill_pid,
  proc_scheduler_if.master    sw,
  output logic [15:0]         active_mask,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, RUN, SEARCH, REQ} state_t;

  localparam logic [QW-1:0] ONE = QW'(1);

  state_t        state;
  logic [QW-1:0] counter;
  logic [3:0]    idx;
  logic [15:0]   mask_next;
  logic          kill_valid;
  logic [QW-1:0] reload;

  // PID 0 is the kernel and can never be killed, so a kill of PID 0 is
  // treated as if no kill happened at all (it also cannot trigger preemption).
  assign kill_valid = proc_kill && (kill_pid != 4'd0);
  assign reload     = (quantum == '0) ? ONE : quantum;

  // Kill is applied after create so that a same-cycle create+kill leaves the PID inactive.
  always_comb begin
    mask_next = active_mask;
    if (proc_create) mask_next[create_pid] = 1'b1;
    if (kill_valid)  mask_next[kill_pid]   = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      counter       <= '0;
      idx           <= 4'd0;
      sw.switch_req <= 1'b0;
      sw.next_pid   <= 4'd0;
      active_mask   <= RESET_MASK;
      busy          <= 1'b0;
    end else begin
      active_mask <= mask_next;
      case (state)
        IDLE: begin
          if (enable) begin
            state   <= RUN;
            counter <= reload;
          end
        end
        RUN: begin
          if (counter == ONE || yield || (kill_valid && kill_pid == cur_pid)) begin
            state <= SEARCH;
            idx   <= cur_pid + 4'd1;
            busy  <= 1'b1;
          end else if (!enable) begin
            state <= IDLE;
          end else begin
            counter <= counter - ONE;
          end
        end
        SEARCH: begin
          // The search tests the mask as updated this cycle, so a PID created
          // or killed right now is already taken into account.
          if (mask_next[idx]) begin
            if (idx != cur_pid) begin
              state         <= REQ;
              sw.next_pid   <= idx;
              sw.switch_req <= 1'b1;
            end else begin
              state   <= RUN;
              counter <= reload;
              busy    <= 1'b0;
            end
          end else begin
            idx <= idx + 4'd1;
          end
        end
        REQ: begin
          if (sw.switch_ack) begin
            state         <= RUN;
            counter       <= reload;
            sw.switch_req <= 1'b0;
            busy          <= 1'b0;
          end else if (kill_valid && kill_pid == sw.next_pid) begin
            state         <= SEARCH;
            idx           <= sw.next_pid + 4'd1;
            sw.switch_req <= 1'b0;
          end
        end
        default: begin
          state         <= IDLE;
          sw.switch_req <= 1'b0;
          busy          <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_proc_scheduler.sv
// Directed walk through the scheduler's scenarios followed by a randomized run,
// every cycle compared against a cycle-level behavioural model.
module tb_proc_scheduler;

  localparam int QW = 16;
  localparam int P_IDLE = 0, P_RUN = 1, P_SEARCH = 2, P_REQ = 3;

  logic          clk;
  logic          reset;
  logic          enable;
  logic [3:0]    cur_pid;
  logic [QW-1:0] quantum;
  logic          yield;
  logic          proc_create;
  logic [3:0]    create_pid;
  logic          proc_kill;
  logic [3:0]    kill_pid;
  logic [15:0]   active_mask;
  logic          busy;

  proc_scheduler_if sw_if ();

  proc_scheduler #(.QW(QW), .RESET_MASK(16'h0001)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .cur_pid     (cur_pid),
    .quantum     (quantum),
    .yield       (yield),
    .proc_create (proc_create),
    .create_pid  (create_pid),
    .proc_kill   (proc_kill),
    .kill_pid    (kill_pid),
    .sw          (sw_if),
    .active_mask (active_mask),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: phase, remaining quantum cycles, search position, chosen PID, mask.
  int          m_phase;
  int          m_left;
  int          m_pos;
  int          m_nxt;
  logic [15:0] m_mask;

  task automatic model_reset();
    m_phase = P_IDLE;
    m_left  = 0;
    m_pos   = 0;
    m_nxt   = 0;
    m_mask  = 16'h0001;
  endtask

  task automatic model_step();
    logic [15:0] nm;
    int cur;
    int slice;
    bit kill_ok;
    cur     = int'(cur_pid);
    slice   = (quantum == 0) ? 1 : int'(quantum);
    kill_ok = proc_kill && (kill_pid != 4'd0);
    nm = m_mask;
    if (proc_create) nm[create_pid] = 1'b1;
    if (kill_ok) nm[kill_pid] = 1'b0;
    if (m_phase == P_IDLE) begin
      if (enable) begin
        m_phase = P_RUN;
        m_left  = slice;
      end
    end else if (m_phase == P_RUN) begin
      if (m_left == 1 || yield || (kill_ok && int'(kill_pid) == cur)) begin
        m_phase = P_SEARCH;
        m_pos   = (cur + 1) % 16;
      end else if (!enable) begin
        m_phase = P_IDLE;
      end else begin
        m_left = m_left - 1;
      end
    end else if (m_phase == P_SEARCH) begin
      if (nm[m_pos]) begin
        if (m_pos != cur) begin
          m_nxt   = m_pos;
          m_phase = P_REQ;
        end else begin
          m_phase = P_RUN;
          m_left  = slice;
        end
      end else begin
        m_pos = (m_pos + 1) % 16;
      end
    end else begin
      if (sw_if.switch_ack) begin
        m_phase = P_RUN;
        m_left  = slice;
      end else if (kill_ok && int'(kill_pid) == m_nxt) begin
        m_phase = P_SEARCH;
        m_pos   = (m_nxt + 1) % 16;
      end
    end
    m_mask = nm;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_output();
    check("switch_req", {15'd0, sw_if.switch_req}, {15'd0, m_phase == P_REQ});
    check("next_pid", {12'd0, sw_if.next_pid}, 16'(m_nxt));
    check("active_mask", active_mask, m_mask);
    check("busy", {15'd0, busy}, {15'd0, (m_phase == P_SEARCH) || (m_phase == P_REQ)});
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_output();
  endtask

  task automatic apply_stimulus(input bit y, input bit cr, input int cp,
                                input bit k, input int kp, input bit ack);
    yield            = y;
    proc_create      = cr;
    create_pid       = 4'(cp);
    proc_kill        = k;
    kill_pid         = 4'(kp);
    sw_if.switch_ack = ack;
    tick();
    yield            = 1'b0;
    proc_create      = 1'b0;
    proc_kill        = 1'b0;
    sw_if.switch_ack = 1'b0;
  endtask

  task automatic wait_req(input int exp_n, input int exp_pid);
    int n;
    n = 0;
    while (sw_if.switch_req !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    check("req_latency", 16'(n), 16'(exp_n));
    check("req_pid", {12'd0, sw_if.next_pid}, 16'(exp_pid));
  endtask

  initial begin
    int n;
    int busy_cnt;
    int req_seen;
    reset = 1'b1; enable = 1'b0; cur_pid = 4'd0; quantum = 16'd4;
    yield = 1'b0; proc_create = 1'b0; create_pid = 4'd0;
    proc_kill = 1'b0; kill_pid = 4'd0; sw_if.switch_ack = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_output();
    reset = 1'b0;

    $display("[TB] sole kernel process");
    enable = 1'b1;
    busy_cnt = 0;
    req_seen = 0;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (busy === 1'b1) busy_cnt++;
      if (sw_if.switch_req !== 1'b0) req_seen++;
    end
    check("sole_search_len", 16'(busy_cnt), 16'd16);
    check("sole_no_req", 16'(req_seen), 16'd0);

    $display("[TB] round robin over 0,3,7");
    reset = 1'b1;
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    enable = 1'b0;
    apply_stimulus(0, 1, 3, 0, 0, 0);
    apply_stimulus(0, 1, 7, 0, 0, 0);
    check("mask_3_7", active_mask, 16'h0089);
    enable = 1'b1;
    wait_req(8, 3);
    apply_stimulus(0, 0, 0, 0, 0, 1);
    cur_pid = 4'd3;
    wait_req(8, 7);
    apply_stimulus(0, 0, 0, 0, 0, 1);
    cur_pid = 4'd7;
    wait_req(13, 0);
    apply_stimulus(0, 0, 0, 0, 0, 1);
    cur_pid = 4'd0;
    wait_req(7, 3);

    $display("[TB] kill pending target");
    apply_stimulus(0, 0, 0, 1, 3, 0);
    check("kill_drops_req", {15'd0, sw_if.switch_req}, 16'd0);
    wait_req(4, 7);

    $display("[TB] yield and kill of running process");
    quantum = 16'd60;
    apply_stimulus(0, 1, 9, 0, 0, 1);
    cur_pid = 4'd7;
    repeat (10) tick();
    apply_stimulus(1, 0, 0, 0, 0, 0);
    check("yield_search", {15'd0, busy}, 16'd1);
    wait_req(2, 9);
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1, 0, 0, 0, 0, 0);
      check("yield_in_req", {15'd0, sw_if.switch_req}, 16'd1);
    end
    apply_stimulus(0, 0, 0, 0, 0, 1);
    cur_pid = 4'd9;
    repeat (10) tick();
    apply_stimulus(0, 0, 0, 1, 9, 0);
    check("kill_cur_search", {15'd0, busy}, 16'd1);
    check("kill_cur_mask", {15'd0, active_mask[9]}, 16'd0);
    wait_req(7, 0);

    $display("[TB] boundary cases");
    quantum = 16'd0;
    apply_stimulus(0, 0, 0, 0, 0, 1);
    cur_pid = 4'd0;
    tick();
    check("q0_one_cycle", {15'd0, busy}, 16'd1);
    apply_stimulus(0, 0, 0, 1, 0, 0);
    check("kill0_ignored", {15'd0, active_mask[0]}, 16'd1);
    apply_stimulus(0, 1, 5, 1, 5, 0);
    check("kill_wins", {15'd0, active_mask[5]}, 16'd0);

    $display("[TB] async reset during request");
    quantum = 16'd3;
    n = 0;
    while (sw_if.switch_req !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    check("req_before_reset", {15'd0, sw_if.switch_req}, 16'd1);
    #1 reset = 1'b1;
    model_reset();
    #1;
    check_output();
    check("reset_mask_now", active_mask, 16'h0001);
    @(posedge clk); #1;
    check_output();
    reset = 1'b0;
    enable = 1'b0;
    repeat (3) tick();

    $display("[TB] randomized traffic");
    cur_pid = 4'd0;
    for (int i = 0; i < 600; i++) begin
      bit ack;
      enable  = ($urandom_range(9) != 0);
      quantum = QW'($urandom_range(5));
      ack     = (m_phase == P_REQ) && ($urandom_range(2) == 0);
      apply_stimulus($urandom_range(19) == 0,
                     $urandom_range(9) == 0, int'($urandom_range(15)),
                     $urandom_range(11) == 0, int'($urandom_range(15, 1)),
                     ack);
      if (ack) cur_pid = 4'(m_nxt);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
